fifo_narrow_to_wide: RTL and testbench

Asymmetric FIFO with a narrow write port and a wide read port. Each write pushes one DATA_WIDTH-bit entry. Each read pops one 2*DATA_WIDTH-bit word built from the two oldest entries. The block contains both the storage and the pointer/flag control. It sits on the producer-to-consumer path where a byte-wide source feeds a word-wide sink, the opposite direction of the team's wide-write/narrow-read FIFO.

---
 rtl/fifo_narrow_to_wide.sv | 124 ++++++++++++
 tb/tb_fifo_narrow_to_wide.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_narrow_to_wide.sv
`default_nettype none
// ============================================================================
// Module      : fifo_narrow_to_wide
// Description : Asymmetric FIFO with a narrow write port and a wide read port.
//               Each accepted write pushes one DATA_WIDTH-bit entry. Each
//               accepted read pops one 2*DATA_WIDTH-bit word built from the
//               two oldest entries. The oldest entry sits in the low half.
//               The read side is first-word fall-through: r_data shows the
//               head word whenever empty is low.
//
// Ports       : clk     - clock, all state updates on the rising edge
//               reset   - asynchronous, active-high reset
//               wr      - write request, pushes w_data when not full
//               w_data  - narrow write data [DATA_WIDTH-1:0]
//               rd      - read request, pops one wide word when not empty
//               r_data  - head word {second-oldest, oldest} [2*DATA_WIDTH-1:0]
//               full    - occupancy == 2^ADDR_WIDTH entries
//               empty   - occupancy < 2 entries (no complete word available)
//               count   - occupancy in narrow entries [ADDR_WIDTH:0]
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_narrow_to_wide #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      rd,
    output logic [2*DATA_WIDTH-1:0]   r_data,
    output logic                      full,
    output logic                      empty,
    output logic [ADDR_WIDTH:0]       count
);

    // Storage depth in narrow entries. ADDR_WIDTH >= 1 keeps this even, so a
    // wide word never straddles the wrap boundary of the storage array.
    localparam int                c_MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FULL_CNT = (ADDR_WIDTH+1)'(c_MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_WORD_CNT = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_PTR_TWO  = (ADDR_WIDTH+1)'(2);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [c_MEM_DEPTH];

    // One extra pointer bit distinguishes full from empty: the pointers are
    // equal only at zero occupancy, and differ by exactly the depth when full.
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;

    // ------------------------------------------------------------------------
    // Combinational occupancy and flags (from registered pointers only)
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr_lo;
    logic [ADDR_WIDTH-1:0] w_rd_addr_hi;

    // Modular subtraction yields the true occupancy across pointer wrap.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_FULL_CNT);
    // A single pending entry is not a complete word, so it reads as empty.
    assign w_empty = (w_count < c_WORD_CNT);

    // Write and read are qualified independently against the current flags.
    // A read needs two stored entries and a write lands at wr_ptr, beyond
    // them, so a same-cycle write can never disturb the word being popped.
    assign w_wr_accept = wr && !w_full;
    assign w_rd_accept = rd && !w_empty;

    assign w_wr_addr    = r_wr_ptr[ADDR_WIDTH-1:0];
    // rd_ptr is always even, so the +1 never carries out of the low bit.
    assign w_rd_addr_lo = r_rd_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr_hi = w_rd_addr_lo + ADDR_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Pointer registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
        end else if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
        end else if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_TWO;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: not reset; contents are meaningless until written.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_wr_addr] <= w_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Fall-through head word, oldest entry in the low half. Don't-care while
    // empty is high.
    assign r_data = {r_mem[w_rd_addr_hi], r_mem[w_rd_addr_lo]};
    assign full   = w_full;
    assign empty  = w_empty;
    assign count  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_narrow_to_wide.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_narrow_to_wide
// Description : Self-checking bench for fifo_narrow_to_wide. Directed
//               stimulus pushes expected wide words into a scoreboard queue;
//               an independent monitor pops and compares on every accepted
//               read. Flag and occupancy checks are made directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_narrow_to_wide;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;

    logic                    clk;
    logic                    reset;
    logic                    wr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    rd;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    full;
    logic                    empty;
    logic [ADDR_WIDTH:0]     count;

    int total;
    int bad;

    logic [2*DATA_WIDTH-1:0] exp_q [$];

    fifo_narrow_to_wide #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change 1 ns after the rising edge, so on the falling
    // edge the request for the coming edge is stable. A read is accepted when
    // rd is high and the FIFO shows a complete word.
    always @(negedge clk) begin
        if (!reset && rd && !empty) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", r_data);
            end else begin
                logic [2*DATA_WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (r_data !== e) begin
                    bad++;
                    $display("FAIL pop_word: got 0x%0h expected 0x%0h", r_data, e);
                end
            end
        end
    end

    // Drive one cycle of requests, then return 1 ns past the edge.
    task automatic step(input logic w, input logic [DATA_WIDTH-1:0] d, input logic r);
        wr     = w;
        w_data = d;
        rd     = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        int nb;
        int cyc;
        total  = 0;
        bad    = 0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1. Reset state and read while empty
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("rd_empty_count", 32'(count), 32'd0);
        check("rd_empty_empty", 32'(empty), 32'd1);

        // 2. Lone entry is never popped
        step(1'b1, 8'hA1, 1'b0);
        check("one_count", 32'(count), 32'd1);
        check("one_empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("one_rd_ignored", 32'(count), 32'd1);
        step(1'b1, 8'hB2, 1'b0);
        check("two_count", 32'(count), 32'd2);
        check("two_empty", 32'(empty), 32'd0);
        check("two_rdata", 32'(r_data), 32'h0000B2A1);
        exp_q.push_back(16'hB2A1);
        step(1'b0, 8'h00, 1'b1);
        check("two_drained", 32'(count), 32'd0);

        // 3. Fill, drop on full, drain
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd8);
        step(1'b1, 8'hFF, 1'b0);
        check("drop_count", 32'(count), 32'd8);
        exp_q.push_back(16'h0201);
        exp_q.push_back(16'h0403);
        exp_q.push_back(16'h0605);
        exp_q.push_back(16'h0807);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // 4a. count=2, write and read together
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        exp_q.push_back(16'h2211);
        step(1'b1, 8'h33, 1'b1);
        check("simul2_count", 32'(count), 32'd1);
        check("simul2_empty", 32'(empty), 32'd1);
        step(1'b1, 8'h44, 1'b0);
        check("simul2_rdata", 32'(r_data), 32'h00004433);
        exp_q.push_back(16'h4433);
        step(1'b0, 8'h00, 1'b1);

        // 4b. Full, write and read together: write dropped
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        check("simulf_full_pre", 32'(full), 32'd1);
        exp_q.push_back(16'h5150);
        step(1'b1, 8'hEE, 1'b1);
        check("simulf_count", 32'(count), 32'd6);
        check("simulf_full",  32'(full),  32'd0);
        exp_q.push_back(16'h5352);
        exp_q.push_back(16'h5554);
        exp_q.push_back(16'h5756);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        check("simulf_drain", 32'(count), 32'd0);

        // 5. Wrap stress with random gating
        for (int k = 0; k < 20; k++) exp_q.push_back({8'(2*k+1), 8'(2*k)});
        nb  = 0;
        cyc = 0;
        while ((nb < 40 || exp_q.size() != 0) && cyc < 2000) begin
            logic w;
            logic r;
            w = (nb < 40) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) != 0);
            if (w && !full) nb++;
            step(w, 8'(nb - ((w && !full) ? 1 : 0)), r);
            if (count > 4'd8) check("wrap_count_max", 32'(count), 32'd8);
            cyc++;
        end
        check("wrap_done", 32'(cyc < 2000), 32'd1);
        check("wrap_count_end", 32'(count), 32'd0);

        // 6. Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        check("pre_reset_count", 32'(count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_full",  32'(full),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        check("post_reset_rdata", 32'(r_data), 32'h0000C35A);
        exp_q.push_back(16'hC35A);
        step(1'b0, 8'h00, 1'b1);
        check("post_reset_count", 32'(count), 32'd0);

        @(posedge clk);
        #1;
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
